// File: rtl/console_out_arbiter.sv
// Console output arbiter: round-robin acceptance of bytes from NREQ producers
// into a circular FIFO, drained onto out_dat with one out_ctl toggle per
// character and at least GAP cycles between successive toggles.
//
// Handshake: a producer raises req_valid[i] with its byte on req_data and
// holds both stable until req_ready[i]; the byte transfers on the rising edge
// where req_valid[i] & req_ready[i]. Dropping valid before ready is allowed.
// req_ready is combinational, at most one-hot, and never set while full.
module console_out_arbiter #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int GAP   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [7:0]               out_dat,
  output logic                     out_ctl,
  output logic                     idle,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'((GAP > 1) ? GAP - 2 : 0);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic {
    ISSUE = 1'b0,
    HOLD  = 1'b1
  } drain_state_e;

  // Arbiter
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] grant_idx;
  logic          grant_vld;
  logic [7:0]    push_data;
  logic          push;
  logic          full;

  // FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    head;
  logic          pop;

  // Drain engine
  drain_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    dat_q, dat_d;
  logic          ctl_q, ctl_d;

  // Full is judged on the registered level, so a same-cycle pop never opens a slot.
  assign full = (level_q == LVL_FULL);
  assign head = mem_q[rptr_q];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    logic [IW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = last_q;
    cand      = last_q;
    if (!full) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IW'((int'(last_q) + k) % NREQ);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // One-hot ready and the byte of the granted requester.
  always_comb begin
    req_ready = '0;
    push_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && (grant_idx == IW'(i))) begin
        req_ready[i] = 1'b1;
        push_data    = req_data[8*i +: 8];
      end
    end
  end

  // A grant is always a transfer: valid is part of the grant condition.
  assign push = grant_vld;

  // Next-state for the round-robin pointer and the FIFO bookkeeping.
  always_comb begin
    last_d  = last_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      last_d = grant_idx;
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // Drain FSM: issue a character when data is present, then hold for GAP-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    ctl_d   = ctl_q;
    pop     = 1'b0;
    case (state_q)
      ISSUE: begin
        if (level_q != '0) begin
          pop   = 1'b1;
          dat_d = head;
          ctl_d = ~ctl_q;
          if (GAP > 1) begin
            cnt_d   = CNT_LOAD;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  // Control and output registers; reset discards everything queued or in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= LAST_RST;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      state_q <= ISSUE;
      cnt_q   <= '0;
      dat_q   <= '0;
      ctl_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ctl_q   <= ctl_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign out_dat   = dat_q;
  assign out_ctl   = ctl_q;
  assign level     = level_q;
  assign idle      = (level_q == '0) && (state_q == ISSUE);
  assign dbg_state = state_q;

endmodule
